// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (core = port 0, DMA = port 1) round-robin arbiter in
// front of a single-ported 32-bit data memory. One transaction is in flight at
// a time: accept (IDLE) -> memory access (ACCESS) -> response (RESP).
// Loads are aligned and sign/zero-extended on the way back; stores get
// byte-enables and lane replication.
// Optional feature macro: DMEM_ARB_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses are refused with err=1 instead of being truncated to
// the naturally aligned offset.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // port 0 (core)
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [2:0]            p0_funct3,
  input  logic [DM_ADDRESS-1:0] p0_addr,
  input  logic [DATA_W-1:0]     p0_wdata,
  output logic                  p0_ready,
  output logic                  p0_rvalid,
  output logic [DATA_W-1:0]     p0_rdata,
  output logic                  p0_err,
  // port 1 (DMA)
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [2:0]            p1_funct3,
  input  logic [DM_ADDRESS-1:0] p1_addr,
  input  logic [DATA_W-1:0]     p1_wdata,
  output logic                  p1_ready,
  output logic                  p1_rvalid,
  output logic [DATA_W-1:0]     p1_rdata,
  output logic                  p1_err,
  // memory side
  output logic [DM_ADDRESS-3:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_q;      // port granted most recently
  logic                  owner_q;     // port owning the transaction in flight
  logic                  we_q;
  logic                  err_q;       // transaction refused: no memory access
  logic [2:0]            funct3_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;

  logic                  grant;
  logic                  accept;
  logic                  sel_we;
  logic                  sel_err;
  logic [2:0]            sel_funct3;
  logic [DM_ADDRESS-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;

  logic                  in_access;
  logic                  in_resp;
  logic                  mem_op;
  logic                  wr_op;
  logic [1:0]            offset;
  logic [3:0]            store_be;
  logic [DATA_W-1:0]     store_data;
  logic [DATA_W-1:0]     shifted;
  logic [DATA_W-1:0]     load_data;
  logic [DATA_W-1:0]     resp_data;

  // Round-robin pick, request attribute mux and the combinational ready strobes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    grant = 1'b0;
    if (p0_req && p1_req) begin
      grant = ~last_q;
    end else if (p1_req) begin
      grant = 1'b1;
    end
    sel_we     = grant ? p1_we     : p0_we;
    sel_funct3 = grant ? p1_funct3 : p0_funct3;
    sel_addr   = grant ? p1_addr   : p0_addr;
    sel_wdata  = grant ? p1_wdata  : p0_wdata;
    p0_ready   = (state_q == ST_IDLE) && !reset && !grant;
    p1_ready   = (state_q == ST_IDLE) && !reset &&  grant;
    accept     = (state_q == ST_IDLE) && !reset && (grant ? p1_req : p0_req);
  end

  // Decide at accept time whether the request is refused (unsupported funct3,
  // and optionally misalignment).
  always_comb begin
    sel_err = 1'b0;
    if (sel_we) begin
      sel_err = !(sel_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      sel_err = sel_funct3 inside {3'b011, 3'b110, 3'b111};
    end
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    if ((sel_funct3[1:0] == 2'b01 && sel_addr[0]) ||
        (sel_funct3[1:0] == 2'b10 && sel_addr[1:0] != 2'b00)) begin
      sel_err = 1'b1;
    end
`endif
  end

  // Next-state logic: fixed three-cycle walk once a request is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register and round-robin pointer; reset favours port 0 next.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) last_q <= grant;
    end
  end

  // Capture the accepted request.
  always_ff @(posedge clk) begin
    // NOTE: these datapath registers are deliberately not reset; they are
    // only observed in ACCESS/RESP, which are always entered via a fresh accept.
    if (accept) begin
      owner_q  <= grant;
      we_q     <= sel_we;
      err_q    <= sel_err;
      funct3_q <= sel_funct3;
      addr_q   <= sel_addr;
      wdata_q  <= sel_wdata;
    end
  end

  // Lane offset, store lane steering and load alignment/extension.
  always_comb begin
    offset     = 2'b00;
    store_be   = 4'b1111;
    store_data = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        offset     = addr_q[1:0];
        store_be   = 4'b0001 << addr_q[1:0];
        store_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        offset     = {addr_q[1], 1'b0};
        store_be   = 4'b0011 << {addr_q[1], 1'b0};
        store_data = {2{wdata_q[15:0]}};
      end
      default: begin
        offset     = 2'b00;
        store_be   = 4'b1111;
        store_data = wdata_q;
      end
    endcase

    shifted = mem_rdata >> {offset, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = shifted;
      3'b100:  load_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      3'b101:  load_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: load_data = '0;
    endcase
    resp_data = (err_q || we_q) ? '0 : load_data;
  end

  // Output drive; reset zeroes everything combinationally in the sampling cycle,
  // which also suppresses a store caught in ACCESS.
  always_comb begin
    in_access = (state_q == ST_ACCESS) && !reset;
    in_resp   = (state_q == ST_RESP)   && !reset;
    mem_op    = in_access && !err_q;
    wr_op     = mem_op && we_q;
    mem_addr  = in_access ? addr_q[DM_ADDRESS-1:2] : '0;
    mem_re    = mem_op && !we_q;
    mem_we    = wr_op;
    mem_be    = wr_op ? store_be   : 4'b0000;
    mem_wdata = wr_op ? store_data : '0;
    p0_rvalid = in_resp && !owner_q;
    p1_rvalid = in_resp &&  owner_q;
    p0_err    = p0_rvalid && err_q;
    p1_err    = p1_rvalid && err_q;
    p0_rdata  = p0_rvalid ? resp_data : '0;
    p1_rdata  = p1_rvalid ? resp_data : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural word
// memory and a response scoreboard (port, data, err, due cycle).
module tb_dmem_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [2:0]    p0_funct3, p1_funct3;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_ready, p0_rvalid, p0_err, p1_ready, p1_rvalid, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-3:0] mem_addr;
  logic          mem_re, mem_we;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_funct3(p0_funct3), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ready(p0_ready), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_funct3(p1_funct3), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ready(p1_ready), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] cyc    = '0;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] due;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Behavioural memory: word i starts as 0xA5A5_00ii, read data one cycle after mem_re.
  logic [31:0] mem [128];
  bit          mem_ready_q = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_ready_q) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hA5A5_0000 | i;
      mem_ready_q <= 1'b1;
    end else begin
      if (mem_we) begin
        if (mem_be[0]) mem[mem_addr][7:0]   <= mem_wdata[7:0];
        if (mem_be[1]) mem[mem_addr][15:8]  <= mem_wdata[15:8];
        if (mem_be[2]) mem[mem_addr][23:16] <= mem_wdata[23:16];
        if (mem_be[3]) mem[mem_addr][31:24] <= mem_wdata[31:24];
      end
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  // Response monitor: pop the scoreboard on each rvalid, check idle outputs otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (p0_rvalid || p1_rvalid) begin
      check("rvalid_onehot", p0_rvalid & p1_rvalid, 0);
      if (sb.size() == 0) begin
        check("unexpected_rvalid", {p1_rvalid, p0_rvalid}, 0);
      end else begin
        e = sb.pop_front();
        check("resp_port", p1_rvalid, e.port);
        check("resp_cycle", cyc, e.due);
        check("resp_rdata", p1_rvalid ? p1_rdata : p0_rdata, e.rdata);
        check("resp_err", p1_rvalid ? p1_err : p0_err, e.err);
        check("other_port_quiet", p1_rvalid ? ((|p0_rdata) | p0_err) : ((|p1_rdata) | p1_err), 0);
      end
    end else begin
      check("idle_outputs", (|p0_rdata) | (|p1_rdata) | p0_err | p1_err, 0);
      if (sb.size() > 0 && sb[0].due < cyc) begin
        check("resp_missing", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  task automatic set_req(input bit port, input bit req, input bit we, input logic [2:0] f3,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (!port) begin
      p0_req = req; p0_we = we; p0_funct3 = f3; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_funct3 = f3; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  function automatic logic rdy(input bit port);
    return port ? p1_ready : p0_ready;
  endfunction

  // One isolated transaction: accept, check the ACCESS cycle, let the monitor
  // check the RESP cycle.
  task automatic single(input string tag, input bit port, input bit we, input logic [2:0] f3,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input int max_wait,
                        input bit exp_re, input bit exp_we, input logic [3:0] exp_be,
                        input logic [DW-1:0] exp_mwdata, input logic [DW-1:0] exp_rdata,
                        input bit exp_err);
    @(negedge clk);
    set_req(port, 1'b1, we, f3, addr, wdata);
    #1;
    for (int k = 0; k < max_wait && !rdy(port); k++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_ready"}, rdy(port), 1);
    if (!rdy(port)) begin
      set_req(port, 1'b0, 1'b0, 3'b000, '0, '0);
      return;
    end
    sb.push_back('{port: port, rdata: exp_rdata, err: exp_err, due: cyc + 2});
    @(posedge clk);
    #1;
    set_req(port, 1'b0, 1'b0, 3'b000, '0, '0);
    @(negedge clk);
    check({tag, "_busy_ready"}, {p1_ready, p0_ready}, 0);
    check({tag, "_mem_re"}, mem_re, exp_re);
    check({tag, "_mem_we"}, mem_we, exp_we);
    check({tag, "_mem_be"}, mem_be, exp_be);
    if (exp_re || exp_we) check({tag, "_mem_addr"}, mem_addr, addr[AW-1:2]);
    if (exp_we) check({tag, "_mem_wdata"}, mem_wdata, exp_mwdata);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 3'b000, '0, '0);
    set_req(1, 1'b0, 1'b0, 3'b000, '0, '0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {p1_ready, p0_ready}, 0);
    check("rst_mem_ctrl", {mem_re, mem_we, mem_be}, 0);
    check("rst_rvalid", {p1_rvalid, p0_rvalid}, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Port 0 SW then LW at 0x010
    single("sw_p0", 0, 1, 3'b010, 9'h010, 32'hDEADBEEF, 2, 0, 1, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
    single("lw_p0", 0, 0, 3'b010, 9'h010, 32'h0, 2, 1, 0, 4'b0000, 32'h0, 32'hDEADBEEF, 0);

    // Port 1 SB 0x013 then LB / LBU (word becomes 0x80ADBEEF)
    single("sb_p1", 1, 1, 3'b000, 9'h013, 32'h00000080, 2, 0, 1, 4'b1000, 32'h80808080, 32'h0, 0);
    single("lb_p1", 1, 0, 3'b000, 9'h013, 32'h0, 2, 1, 0, 4'b0000, 32'h0, 32'hFFFFFF80, 0);
    single("lbu_p1", 1, 0, 3'b100, 9'h013, 32'h0, 2, 1, 0, 4'b0000, 32'h0, 32'h00000080, 0);

    // Port 1 SH upper half of word 12, then LHU / LH back on port 0
    single("sh_p1", 1, 1, 3'b001, 9'h032, 32'h0000CAFE, 2, 0, 1, 4'b1100, 32'hCAFECAFE, 32'h0, 0);
    single("lhu_p0", 0, 0, 3'b101, 9'h032, 32'h0, 2, 1, 0, 4'b0000, 32'h0, 32'h0000CAFE, 0);
    single("lh_p0", 0, 0, 3'b001, 9'h032, 32'h0, 2, 1, 0, 4'b0000, 32'h0, 32'hFFFFCAFE, 0);

    // Misaligned LH 0x011 (word 0x80ADBEEF)
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    single("lh_mis", 0, 0, 3'b001, 9'h011, 32'h0, 2, 0, 0, 4'b0000, 32'h0, 32'h0, 1);
`else
    single("lh_mis", 0, 0, 3'b001, 9'h011, 32'h0, 2, 1, 0, 4'b0000, 32'h0, 32'hFFFFBEEF, 0);
`endif

    // Unsupported funct3: load 011 and store 011
    single("ld_f3_011", 0, 0, 3'b011, 9'h010, 32'h0, 2, 0, 0, 4'b0000, 32'h0, 32'h0, 1);
    single("st_f3_011", 1, 1, 3'b011, 9'h014, 32'h11223344, 2, 0, 0, 4'b0000, 32'h0, 32'h0, 1);

    // Reset during ACCESS of a SW to 0x020: store suppressed, no response
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 3'b010, 9'h020, 32'h12345678);
    #1;
    check("rstacc_ready", p0_ready, 1);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 1'b0, 3'b000, '0, '0);
    reset = 1'b1;
    @(negedge clk);
    check("rstacc_mem_we", mem_we, 0);
    check("rstacc_mem_be", mem_be, 0);
    check("rstacc_rvalid", {p1_rvalid, p0_rvalid}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rstacc_mem_word", mem[8], 32'hA5A50008);
    single("rstacc_lw", 0, 0, 3'b010, 9'h020, 32'h0, 0, 1, 0, 4'b0000, 32'h0, 32'hA5A50008, 0);

    // Round robin: both ports request every IDLE, six grants 0,1,0,1,0,1
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
    set_req(1, 1'b1, 1'b0, 3'b001, 9'h012, 32'h0);
    for (int g = 0; g < 6; g++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        #1;
        if (p0_ready || p1_ready) break;
      end
      check("rr_ready", p0_ready | p1_ready, 1);
      check("rr_onehot", p0_ready & p1_ready, 0);
      check("rr_grant", p1_ready, g % 2);
      if (g % 2 == 0) sb.push_back('{port: 1'b0, rdata: 32'h80ADBEEF, err: 1'b0, due: cyc + 2});
      else            sb.push_back('{port: 1'b1, rdata: 32'hFFFF80AD, err: 1'b0, due: cyc + 2});
      @(posedge clk);
    end
    #1;
    set_req(0, 1'b0, 1'b0, 3'b000, '0, '0);
    set_req(1, 1'b0, 1'b0, 3'b000, '0, '0);
    repeat (5) @(negedge clk);

    check("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
